// File: rtl/wallace_final_cpa.sv
// wallace_final_cpa: final carry-propagate stage of the 32x32 Wallace multiplier.
// Adds the last CSA sum/carry pair in two pipeline stages (low half, then high
// half plus the low-half carry) and hands {product, tag} to the CDB arbiter
// over a valid/ready handshake. Two ops can be in flight; stalls back-pressure
// upstream without losing or duplicating work.
// Optional feature macro: WALLACE_CPA_FLUSH_EN (flush kills all in-flight ops).
module wallace_final_cpa #(
  parameter int W     = 64,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     sum_vec,
  input  logic [W-1:0]     carry_vec,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     product,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int H = W / 2;

  typedef struct packed {
    logic [H-1:0]     lo;
    logic             c;
    logic [H-1:0]     sum_hi;
    logic [H-1:0]     carry_hi;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [W-1:0]     prod;
    logic [TAG_W-1:0] tag;
  } s2_t;

  s1_t  s1_q;
  s2_t  s2_q;
  logic s1_valid, s2_valid;
  logic s2_free, s1_adv, accept, kill;
  logic [H:0]   lo_sum;
  logic [H-1:0] hi_sum;

`ifdef WALLACE_CPA_FLUSH_EN
  assign kill = flush;
`else
  // Port kept for a uniform interface; it has no effect in this build.
  logic unused_flush;
  assign unused_flush = flush;
  assign kill = 1'b0;
`endif

  // Handshake: S1 drains into S2 whenever S2 is empty or leaving this cycle.
  assign s2_free  = !s2_valid | out_ready;
  assign s1_adv   = s1_valid & s2_free;
  assign in_ready = (!s1_valid | s1_adv) & !kill;
  assign accept   = in_valid & in_ready;

  // Low half with carry-out; high half folds in the registered carry.
  assign lo_sum = {1'b0, sum_vec[H-1:0]} + {1'b0, carry_vec[H-1:0]};
  assign hi_sum = s1_q.sum_hi + s1_q.carry_hi + {{(H-1){1'b0}}, s1_q.c};

  // Stage occupancy; reset beats flush beats normal flow.
  always_ff @(posedge clk) begin
    if (rst || kill) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_adv | (s2_valid & !out_ready);
      s1_valid <= accept | (s1_valid & !s1_adv);
    end
  end

  // Stage data loads only on its own advance, so S2 holds through CDB stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      if (accept) begin
        s1_q.lo       <= lo_sum[H-1:0];
        s1_q.c        <= lo_sum[H];
        s1_q.sum_hi   <= sum_vec[W-1:H];
        s1_q.carry_hi <= carry_vec[W-1:H];
        s1_q.tag      <= in_tag;
      end
      if (s1_adv) begin
        s2_q.prod <= {hi_sum, s1_q.lo};
        s2_q.tag  <= s1_q.tag;
      end
    end
  end

  assign out_valid = s2_valid;
  assign product   = s2_q.prod;
  assign out_tag   = s2_q.tag;
  assign busy      = s1_valid | s2_valid;
endmodule

// File: tb/tb_wallace_final_cpa.sv
// Bench for wallace_final_cpa: directed scenarios plus random traffic, with a
// transaction-level scoreboard (queue of expected {sum+carry, tag, age}).
module tb_wallace_final_cpa;
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0, out_ready = 0, flush = 0;
  logic        in_ready, out_valid, busy;
  logic [63:0] sum_vec = '0, carry_vec = '0, product;
  logic [3:0]  in_tag = '0, out_tag;

  int checks = 0, failures = 0;
  int cyc = 0, acc_cnt = 0, out_cnt = 0;

  typedef struct { logic [63:0] p; logic [3:0] t; int age; } op_t;
  op_t  q[$];
  logic [3:0] otag_q[$];
  int   ocyc_q[$];

  wallace_final_cpa #(.W(64), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sum_vec(sum_vec), .carry_vec(carry_vec), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .product(product),
    .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard: an op becomes visible one edge after acceptance if it is the
  // oldest; with two held and the CDB stalled, nothing more can enter.
  always @(negedge clk) begin
    logic exp_ir, exp_ov, kill;
    if (rst) begin
      q.delete();
    end else begin
      kill = 1'b0;
`ifdef WALLACE_CPA_FLUSH_EN
      kill = flush;
`endif
      exp_ov = (q.size() > 0) && (q[0].age >= 1);
      exp_ir = !(q.size() == 2 && !out_ready) && !kill;
      checks++;
      if (in_ready !== exp_ir) begin failures++; $display("FAIL in_ready got=%b exp=%b t=%0t", in_ready, exp_ir, $time); end
      checks++;
      if (out_valid !== exp_ov) begin failures++; $display("FAIL out_valid got=%b exp=%b t=%0t", out_valid, exp_ov, $time); end
      checks++;
      if (busy !== (q.size() > 0)) begin failures++; $display("FAIL busy got=%b exp=%b t=%0t", busy, q.size() > 0, $time); end
      if (exp_ov) begin
        checks++;
        if (product !== q[0].p) begin failures++; $display("FAIL product got=%h exp=%h t=%0t", product, q[0].p, $time); end
        checks++;
        if (out_tag !== q[0].t) begin failures++; $display("FAIL out_tag got=%0d exp=%0d t=%0t", out_tag, q[0].t, $time); end
      end
      if (kill) begin
        q.delete();
      end else begin
        if (exp_ov && out_ready) begin
          void'(q.pop_front());
          otag_q.push_back(out_tag);
          ocyc_q.push_back(cyc);
          out_cnt++;
        end
        for (int i = 0; i < q.size(); i++) q[i].age++;
        if (in_valid && exp_ir) begin
          q.push_back('{p: sum_vec + carry_vec, t: in_tag, age: 0});
          acc_cnt++;
        end
      end
    end
  end

  // Present one op and hold it until taken; returns just after the accepting edge.
  task automatic send(input logic [63:0] s, input logic [63:0] c, input logic [3:0] t, output int waited);
    in_valid = 1; sum_vec = s; carry_vec = c; in_tag = t; waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin waited++; @(negedge clk); end
    if (!in_ready) begin checks++; failures++; $display("FAIL send_timeout tag=%0d", t); end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    in_valid = 0;
    @(negedge clk);
    while (busy && n < 100) begin n++; @(negedge clk); end
    if (busy) begin checks++; failures++; $display("FAIL drain_timeout busy=%b exp=0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (product !== 64'h0) begin failures++; $display("FAIL reset_product got=%h exp=0", product); end
    checks++; if (out_tag !== 4'h0) begin failures++; $display("FAIL reset_out_tag got=%0d exp=0", out_tag); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_cross_half();
    int w, lat;
    out_ready = 1;
    send(64'h0000_0000_FFFF_FFFF, 64'h1, 4'd3, w);
    in_valid = 0;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin lat = i; break; end
    end
    checks++; if (lat != 1) begin failures++; $display("FAIL cross_latency got=%0d exp=1", lat); end
    checks++; if (product !== 64'h0000_0001_0000_0000) begin failures++; $display("FAIL cross_product got=%h exp=0000000100000000", product); end
    checks++; if (out_tag !== 4'd3) begin failures++; $display("FAIL cross_tag got=%0d exp=3", out_tag); end
    wait_idle();
  endtask

  task automatic test_full_multiply();
    int w;
    logic got;
    logic [63:0] exp_p [2];
    logic [63:0] s_v [2];
    logic [63:0] c_v [2];
    exp_p[0] = 64'hFFFF_FFFE_0000_0001; s_v[0] = 64'hFFFF_FFFC_FFFF_FFFF; c_v[0] = 64'h0000_0001_0000_0002;
    exp_p[1] = 64'h0;                   s_v[1] = 64'h8000_0000_0000_0000; c_v[1] = 64'h8000_0000_0000_0000;
    out_ready = 1;
    for (int k = 0; k < 2; k++) begin
      send(s_v[k], c_v[k], 4'(k + 5), w);
      in_valid = 0;
      got = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (out_valid) begin got = 1; break; end
      end
      checks++;
      if (!got || product !== exp_p[k]) begin failures++; $display("FAIL mult_product case=%0d got=%h exp=%h", k, product, exp_p[k]); end
      wait_idle();
    end
  endtask

  task automatic test_back_to_back();
    int w, o0;
    out_ready = 1;
    otag_q.delete(); ocyc_q.delete();
    o0 = out_cnt;
    for (int t = 0; t < 8; t++) begin
      send({$urandom, $urandom}, {$urandom, $urandom}, 4'(t), w);
      checks++; if (w != 0) begin failures++; $display("FAIL b2b_in_ready tag=%0d stall_cycles=%0d exp=0", t, w); end
    end
    wait_idle();
    checks++; if (out_cnt - o0 != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", out_cnt - o0); end
    for (int t = 0; t < 8 && t < otag_q.size(); t++) begin
      checks++; if (otag_q[t] !== 4'(t)) begin failures++; $display("FAIL b2b_order idx=%0d got=%0d exp=%0d", t, otag_q[t], t); end
      if (t > 0) begin
        checks++; if (ocyc_q[t] != ocyc_q[t-1] + 1) begin failures++; $display("FAIL b2b_gap idx=%0d got=%0d exp=%0d", t, ocyc_q[t], ocyc_q[t-1] + 1); end
      end
    end
  endtask

  task automatic test_stall();
    int a0, o0, k;
    logic fired;
    out_ready = 0;
    a0 = acc_cnt; o0 = out_cnt; k = 0;
    otag_q.delete();
    in_valid = 1; sum_vec = {$urandom, $urandom}; carry_vec = {$urandom, $urandom}; in_tag = 4'd9;
    repeat (5) begin
      @(negedge clk); fired = in_ready;
      @(posedge clk); #1;
      if (fired) begin k++; sum_vec = {$urandom, $urandom}; carry_vec = {$urandom, $urandom}; in_tag = 4'(9 + k); end
    end
    checks++; if (acc_cnt - a0 != 2) begin failures++; $display("FAIL stall_accepts got=%0d exp=2", acc_cnt - a0); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    in_valid = 0; out_ready = 1;
    wait_idle();
    checks++; if (out_cnt - o0 != 2) begin failures++; $display("FAIL stall_drain got=%0d exp=2", out_cnt - o0); end
    checks++; if (otag_q.size() != 2 || otag_q[0] !== 4'd9 || otag_q[1] !== 4'd10) begin
      failures++; $display("FAIL stall_order got_n=%0d exp=2 (tags 9,10)", otag_q.size());
    end
  endtask

  task automatic test_flush();
    int w, a0, o0;
    out_ready = 0;
    send(64'h11, 64'h22, 4'd1, w);
    send(64'h33, 64'h44, 4'd2, w);
    a0 = acc_cnt; o0 = out_cnt;
    in_valid = 1; sum_vec = 64'h55; carry_vec = 64'h66; in_tag = 4'd4; flush = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
`ifdef WALLACE_CPA_FLUSH_EN
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", busy); end
    checks++; if (acc_cnt != a0) begin failures++; $display("FAIL flush_accept got=%0d exp=%0d", acc_cnt, a0); end
    @(posedge clk); #1;
`else
    out_ready = 1;
    wait_idle();
    checks++; if (out_cnt - o0 != 2) begin failures++; $display("FAIL noflush_results got=%0d exp=2", out_cnt - o0); end
    checks++; if (acc_cnt != a0) begin failures++; $display("FAIL noflush_accept got=%0d exp=%0d", acc_cnt, a0); end
`endif
    out_ready = 1;
  endtask

  task automatic test_reset_mid_flight();
    int w;
    out_ready = 0;
    send({$urandom, $urandom}, 64'h7, 4'd6, w);
    send({$urandom, $urandom}, 64'h9, 4'd7, w);
    in_valid = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (product !== 64'h0) begin failures++; $display("FAIL rstmid_product got=%h exp=0", product); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    out_ready = 1;
  endtask

  task automatic test_random();
    int o0;
    o0 = out_cnt;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      sum_vec   = {$urandom, $urandom};
      carry_vec = {$urandom, $urandom};
      in_tag    = 4'($urandom);
      @(posedge clk); #1;
    end
    out_ready = 1;
    wait_idle();
    checks++; if (out_cnt - o0 < 50) begin failures++; $display("FAIL random_traffic got=%0d exp>=50", out_cnt - o0); end
  endtask

  initial begin
    test_reset();
    test_cross_half();
    test_full_multiply();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid_flight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
